// File: rtl/esaxi_emesh_arb.sv
// Burst-locked round-robin arbiter merging AXI read/write beat streams onto the
// single emesh tx port, with credit tracking of in-flight emesh reads.
module esaxi_emesh_arb #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned CW      = 4
) (
  input  logic          clk,
  input  logic          s_axi_aresetn,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_req_addr,
  input  logic [2:0]    rd_req_size,
  input  logic          rd_req_last,
  input  logic          wr_req_valid,
  output logic          wr_req_ready,
  input  logic [AW-1:0] wr_req_addr,
  input  logic [DW-1:0] wr_req_data,
  input  logic [2:0]    wr_req_size,
  input  logic          wr_req_last,
  output logic          emesh_access,
  output logic          emesh_write,
  output logic [AW-1:0] emesh_addr,
  output logic [DW-1:0] emesh_data,
  output logic [1:0]    emesh_size,
  input  logic          emesh_wait,
  input  logic          rd_resp_valid,
  output logic [CW-1:0] rd_outstanding,
  output logic          grant_rd,
  output logic          grant_wr,
  output logic          err_underflow
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          last_wr, last_wr_nx;
  logic          access_nx, write_nx, err_nx;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] data_nx;
  logic [1:0]    size_nx;
  logic [CW-1:0] out_nx;
  logic          slot_free, rd_acc, wr_acc;

  // Size codes of a word and above all map to the 32-bit datamode.
  function automatic logic [1:0] size_map(input logic [2:0] s);
    return (s >= 3'd2) ? 2'b10 : s[1:0];
  endfunction

  assign slot_free    = !emesh_access || !emesh_wait;
  assign rd_req_ready = (state == RD_BURST) && slot_free && (rd_outstanding < CW'(MAX_OUT));
  assign wr_req_ready = (state == WR_BURST) && slot_free;
  assign rd_acc       = rd_req_valid && rd_req_ready;
  assign wr_acc       = wr_req_valid && wr_req_ready;
  assign grant_rd     = (state == RD_BURST);
  assign grant_wr     = (state == WR_BURST);

  always_comb begin
    state_nx   = state;
    last_wr_nx = last_wr;
    access_nx  = emesh_access;
    write_nx   = emesh_write;
    addr_nx    = emesh_addr;
    data_nx    = emesh_data;
    size_nx    = emesh_size;
    out_nx     = rd_outstanding;
    err_nx     = err_underflow;

    unique case (state)
      IDLE: begin
        if (rd_req_valid && wr_req_valid) state_nx = last_wr ? RD_BURST : WR_BURST;
        else if (rd_req_valid)            state_nx = RD_BURST;
        else if (wr_req_valid)            state_nx = WR_BURST;
      end
      RD_BURST: if (rd_acc && rd_req_last) begin
        state_nx   = IDLE;
        last_wr_nx = 1'b0;
      end
      WR_BURST: if (wr_acc && wr_req_last) begin
        state_nx   = IDLE;
        last_wr_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    // A stalled slot keeps every emesh field frozen.
    if (rd_acc) begin
      access_nx = 1'b1;
      write_nx  = 1'b0;
      addr_nx   = rd_req_addr;
      data_nx   = '0;
      size_nx   = size_map(rd_req_size);
    end else if (wr_acc) begin
      access_nx = 1'b1;
      write_nx  = 1'b1;
      addr_nx   = wr_req_addr;
      data_nx   = wr_req_data;
      size_nx   = size_map(wr_req_size);
    end else if (slot_free) begin
      access_nx = 1'b0;
    end

    unique case ({rd_acc, rd_resp_valid})
      2'b10: out_nx = rd_outstanding + CW'(1);
      2'b01: begin
        if (rd_outstanding == '0) err_nx = 1'b1;
        else                      out_nx = rd_outstanding - CW'(1);
      end
      default: out_nx = rd_outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state          <= IDLE;
      last_wr        <= 1'b1;
      emesh_access   <= 1'b0;
      emesh_write    <= 1'b0;
      emesh_addr     <= '0;
      emesh_data     <= '0;
      emesh_size     <= '0;
      rd_outstanding <= '0;
      err_underflow  <= 1'b0;
    end else begin
      state          <= state_nx;
      last_wr        <= last_wr_nx;
      emesh_access   <= access_nx;
      emesh_write    <= write_nx;
      emesh_addr     <= addr_nx;
      emesh_data     <= data_nx;
      emesh_size     <= size_nx;
      rd_outstanding <= out_nx;
      err_underflow  <= err_nx;
    end
  end

endmodule

// File: tb/tb_esaxi_emesh_arb.sv
// Directed bench for esaxi_emesh_arb: arbitration order, credit limit, wait
// stalls, underflow flag, size clamp and mid-burst reset.
module tb_esaxi_emesh_arb;
  logic        clk = 1'b0;
  logic        s_axi_aresetn;
  logic        rd_req_valid, rd_req_ready, rd_req_last;
  logic [31:0] rd_req_addr;
  logic [2:0]  rd_req_size;
  logic        wr_req_valid, wr_req_ready, wr_req_last;
  logic [31:0] wr_req_addr, wr_req_data;
  logic [2:0]  wr_req_size;
  logic        emesh_access, emesh_write, emesh_wait, rd_resp_valid;
  logic [31:0] emesh_addr, emesh_data;
  logic [1:0]  emesh_size;
  logic [3:0]  rd_outstanding;
  logic        grant_rd, grant_wr, err_underflow;

  int passed = 0;
  int total  = 0;

  esaxi_emesh_arb #(.AW(32), .DW(32), .MAX_OUT(8), .CW(4)) dut (
    .clk(clk), .s_axi_aresetn(s_axi_aresetn),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_size(rd_req_size), .rd_req_last(rd_req_last),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_req_size(wr_req_size), .wr_req_last(wr_req_last),
    .emesh_access(emesh_access), .emesh_write(emesh_write), .emesh_addr(emesh_addr),
    .emesh_data(emesh_data), .emesh_size(emesh_size), .emesh_wait(emesh_wait),
    .rd_resp_valid(rd_resp_valid), .rd_outstanding(rd_outstanding),
    .grant_rd(grant_rd), .grant_wr(grant_wr), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    s_axi_aresetn = 1'b0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_size = 3'd2; rd_req_last = 1'b0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_size = 3'd2; wr_req_last = 1'b0;
    emesh_wait = 1'b0; rd_resp_valid = 1'b0;
    tick(); tick();
    chk("rst_access", 64'(emesh_access), 64'(0));
    chk("rst_grant", 64'({grant_rd, grant_wr}), 64'(0));
    chk("rst_out", 64'(rd_outstanding), 64'(0));
    chk("rst_err", 64'(err_underflow), 64'(0));
    s_axi_aresetn = 1'b1;

    // Both requesting: read wins from reset, then write, then read again.
    rd_req_valid = 1'b1; rd_req_addr = 32'h10; rd_req_last = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = 32'h20; wr_req_data = 32'h11; wr_req_last = 1'b1;
    #1 chk("rr_idle_rdy", 64'({rd_req_ready, wr_req_ready}), 64'(0));
    tick();
    chk("rr1_grant", 64'({grant_rd, grant_wr}), 64'(2'b10));
    tick();
    chk("rr1_beat", 64'({emesh_access, emesh_write}), 64'(2'b10));
    chk("rr1_addr", 64'(emesh_addr), 64'(32'h10));
    chk("rr1_idle", 64'({grant_rd, grant_wr}), 64'(0));
    tick();
    chk("rr2_grant", 64'({grant_rd, grant_wr}), 64'(2'b01));
    chk("rr2_gap", 64'(emesh_access), 64'(0));
    tick();
    chk("rr2_beat", 64'({emesh_access, emesh_write}), 64'(2'b11));
    chk("rr2_data", 64'(emesh_data), 64'(32'h11));
    chk("rr2_out", 64'(rd_outstanding), 64'(1));
    tick();
    chk("rr3_grant", 64'({grant_rd, grant_wr}), 64'(2'b10));
    tick();
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    chk("rr3_out", 64'(rd_outstanding), 64'(2));
    rd_resp_valid = 1'b1; tick(); tick(); rd_resp_valid = 1'b0;
    chk("drain1", 64'(rd_outstanding), 64'(0));

    // Four-beat read burst.
    rd_req_valid = 1'b1; rd_req_addr = 32'h100; rd_req_size = 3'd2; rd_req_last = 1'b0;
    tick();
    chk("b4_grant", 64'(grant_rd), 64'(1));
    for (int i = 0; i < 4; i++) begin
      rd_req_addr = 32'h100 + 32'(4 * i);
      rd_req_last = (i == 3);
      #1 chk("b4_ready", 64'(rd_req_ready), 64'(1));
      tick();
      chk("b4_addr", 64'({emesh_access, emesh_write, emesh_addr}), {32'd0, 2'b10, 32'h100 + 32'(4 * i)});
      chk("b4_size", 64'(emesh_size), 64'(2));
      chk("b4_out", 64'(rd_outstanding), 64'(i + 1));
    end
    rd_req_valid = 1'b0; rd_req_last = 1'b0;
    chk("b4_idle", 64'(grant_rd), 64'(0));
    tick();
    chk("b4_drop", 64'(emesh_access), 64'(0));
    rd_resp_valid = 1'b1; repeat (4) tick(); rd_resp_valid = 1'b0;
    chk("drain2", 64'(rd_outstanding), 64'(0));

    // Ten-beat read against an eight-deep credit limit.
    rd_req_valid = 1'b1; rd_req_addr = 32'h400;
    tick();
    for (int i = 0; i < 8; i++) begin
      rd_req_addr = 32'h400 + 32'(4 * i);
      tick();
    end
    rd_req_addr = 32'h420;
    #1 chk("cr_full_rdy", 64'(rd_req_ready), 64'(0));
    chk("cr_full_out", 64'(rd_outstanding), 64'(8));
    tick();
    chk("cr_stall", 64'({emesh_access, grant_rd}), 64'(2'b01));
    chk("cr_stall_out", 64'(rd_outstanding), 64'(8));
    rd_resp_valid = 1'b1;
    tick();
    rd_resp_valid = 1'b0;
    #1 chk("cr_credit_rdy", 64'(rd_req_ready), 64'(1));
    tick();
    chk("cr_b9", 64'({emesh_access, emesh_addr}), {31'd0, 1'b1, 32'h420});
    chk("cr_b9_out", 64'(rd_outstanding), 64'(8));
    rd_req_addr = 32'h424; rd_req_last = 1'b1;
    rd_resp_valid = 1'b1; tick(); rd_resp_valid = 1'b0;
    tick();
    chk("cr_b10", 64'(emesh_addr), 64'(32'h424));
    chk("cr_b10_idle", 64'({grant_rd, rd_outstanding}), 64'(5'h08));
    rd_req_valid = 1'b0; rd_req_last = 1'b0;
    rd_resp_valid = 1'b1; repeat (8) tick(); rd_resp_valid = 1'b0;
    chk("drain3", 64'({err_underflow, rd_outstanding}), 64'(0));

    // Write beat frozen under three cycles of emesh_wait.
    wr_req_valid = 1'b1; wr_req_addr = 32'h2000; wr_req_data = 32'hDEADBEEF; wr_req_last = 1'b0;
    tick(); tick();
    chk("wt_beat", 64'({emesh_access, emesh_write}), 64'(2'b11));
    emesh_wait = 1'b1; wr_req_addr = 32'h2004; wr_req_data = 32'h12345678; wr_req_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("wt_rdy", 64'(wr_req_ready), 64'(0));
      tick();
      chk("wt_hold", {emesh_addr, emesh_data}, {32'h2000, 32'hDEADBEEF});
      chk("wt_acc", 64'(emesh_access), 64'(1));
    end
    emesh_wait = 1'b0;
    #1 chk("wt_rel_rdy", 64'(wr_req_ready), 64'(1));
    tick();
    chk("wt_next", {emesh_addr, emesh_data}, {32'h2004, 32'h12345678});
    wr_req_valid = 1'b0; wr_req_last = 1'b0;
    tick();
    chk("wt_drop", 64'({emesh_access, grant_wr}), 64'(0));

    // Response with nothing outstanding; size-3 read clamps to word.
    rd_resp_valid = 1'b1; tick(); rd_resp_valid = 1'b0;
    chk("uf_set", 64'({err_underflow, rd_outstanding}), 64'(5'h10));
    tick();
    chk("uf_sticky", 64'(err_underflow), 64'(1));
    rd_req_valid = 1'b1; rd_req_addr = 32'h300; rd_req_size = 3'd3; rd_req_last = 1'b1;
    tick(); tick();
    rd_req_valid = 1'b0; rd_req_last = 1'b0; rd_req_size = 3'd2;
    chk("sz_clamp", 64'(emesh_size), 64'(2'b10));
    chk("sz_out", 64'(rd_outstanding), 64'(1));

    // Reset mid write burst, read pending: read wins after release.
    wr_req_valid = 1'b1; wr_req_addr = 32'h3000; wr_req_data = 32'hAA; wr_req_last = 1'b0;
    tick(); tick();
    chk("mr_beat", 64'({emesh_access, grant_wr}), 64'(2'b11));
    rd_req_valid = 1'b1; rd_req_addr = 32'h500; rd_req_last = 1'b1;
    #1 s_axi_aresetn = 1'b0;
    #1 chk("mr_out0", 64'({emesh_access, emesh_write, grant_rd, grant_wr, err_underflow}), 64'(0));
    chk("mr_bus0", {emesh_addr, emesh_data}, 64'(0));
    chk("mr_cnt0", 64'({emesh_size, rd_outstanding}), 64'(0));
    tick();
    s_axi_aresetn = 1'b1;
    tick();
    chk("mr_grant", 64'({grant_rd, grant_wr}), 64'(2'b10));
    tick();
    chk("mr_read", 64'({emesh_access, emesh_write, emesh_addr}), {30'd0, 2'b10, 32'h500});
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
